deserializer_frame_unit: RTL and testbench
==========================================

DESERIALIZER_FRAME_UNIT -- requirements
Module: deserializer_frame_unit

Interface
REQ-001: Parameter WORD_W, default 32, width of each recovered word.
REQ-002: Parameter N_WORDS, default 8, number of words per frame (frame length F = N_WORDS*WORD_W bits).
REQ-003: CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005: SERIAL_IN  input  1  serial data bit, taken from the upstream serializer's SERIAL_OUT.
REQ-006: BIT_VALID  input  1  SERIAL_IN is sampled only on edges where BIT_VALID=1.
REQ-007: START  input  1  frame-start marker; the bit presented with START=1 and BIT_VALID=1 is frame bit 0.
REQ-008: OUT_ACK  input  1  consumer acknowledge for the held frame.
REQ-009: CLR_OVR  input  1  clears the OVERRUN flag.
REQ-010: PAR_OUT  output  N_WORDS*WORD_W  recovered frame; word 1 in the MSBs, word N_WORDS in the LSBs.
REQ-011: OUT_VALID  output  1  PAR_OUT holds an unacknowledged frame.
REQ-012: BUSY  output  1  high while in SHIFT state.
REQ-013: OVERRUN  output  1  sticky; a completed frame was dropped.
REQ-014: ABORT  output  1  one-cycle pulse; a partial frame was discarded.
REQ-015: BIT_COUNT  output  log2(WORD_W)  bit index within the current word.
REQ-016: WORD_COUNT  output  log2(N_WORDS)  index of the current word (0 = word 1).

Function
REQ-017: Bit order SHALL be MSB-first within a word and word 1 first, matching the serializer's transmit order.
REQ-018: State machine SHALL have two states: IDLE and SHIFT.
REQ-019: IDLE -> SHIFT SHALL occur on an edge with START=1 and BIT_VALID=1; that bit SHALL be stored as bit 0; BIT_COUNT SHALL then read 1 and WORD_COUNT 0.
REQ-020: In IDLE, bits with START=0 SHALL be ignored.
REQ-021: In SHIFT, each edge with BIT_VALID=1 SHALL shift SERIAL_IN into an F-bit shift register; BIT_VALID=0 SHALL hold all state.
REQ-022: BIT_COUNT SHALL wrap from WORD_W-1 to 0, and WORD_COUNT SHALL increment on that same edge.
REQ-023: On the edge that samples bit F-1, the FSM SHALL return to IDLE and both counters SHALL clear to 0.
REQ-024: Completion latency: PAR_OUT update and OUT_VALID rise SHALL be visible the cycle after the final bit is sampled.
REQ-025: OUT_VALID SHALL stay high and PAR_OUT SHALL stay stable until an edge with OUT_ACK=1, which clears OUT_VALID.
REQ-026: If a frame completes while OUT_VALID=1 and OUT_ACK=0: the new frame SHALL be dropped, PAR_OUT SHALL be kept, and OVERRUN SHALL be set.
REQ-027: If a frame completes on the same edge as OUT_ACK=1: the new frame SHALL load, OUT_VALID SHALL stay 1, and no overrun SHALL be flagged.
REQ-028: START=1 with BIT_VALID=1 while in SHIFT SHALL discard the partial frame, pulse ABORT, and treat the current bit as bit 0 of a new frame.
REQ-029: START with BIT_VALID=0 SHALL be ignored in both states.
REQ-030: CLR_OVR=1 SHALL clear OVERRUN; if an overrun occurs on the same edge, set SHALL win.
REQ-031: OUT_ACK while OUT_VALID=0 SHALL have no effect.

Reset
REQ-032: RESET=0 SHALL immediately force IDLE, PAR_OUT=0, OUT_VALID=0, BUSY=0, OVERRUN=0, ABORT=0, BIT_COUNT=0, WORD_COUNT=0, and shift register=0.
REQ-033: Reset asserted mid-frame SHALL discard the frame without pulsing ABORT; after release, reception SHALL resume only on a new START.

Verification
REQ-034: Single frame: send words FFFFFFFF, 3FFFFFFF, 8FFFFFFF, 1FFFFFFF, 00005BA0, 00003044, 000030A8, 00000001 with contiguous BIT_VALID -> OUT_VALID rises 257 cycles after the START cycle and PAR_OUT matches these words exactly.
REQ-035: Gapped input: BIT_VALID=0 on every third cycle during the same frame -> identical PAR_OUT; BIT_COUNT/WORD_COUNT frozen during the gaps.
REQ-036: Back-to-back frames with no OUT_ACK -> the second frame is dropped, OVERRUN=1, PAR_OUT still holds frame 1; CLR_OVR pulse -> OVERRUN=0.
REQ-037: OUT_ACK coincident with the second frame's final bit -> PAR_OUT holds frame 2 (words 00000002, 00000003, 00000004, 00000005, rest as in REQ-034), OUT_VALID continuous, OVERRUN=0.
REQ-038: START reasserted at bit 100 -> one-cycle ABORT pulse; the next 256 bits form a frame; no stale bits appear in PAR_OUT.
REQ-039: RESET=0 at bit 40, released 3 cycles later, then a full frame sent -> all outputs 0 during reset, ABORT never pulses, and the subsequent frame is recovered correctly.

Source files
------------

// File: rtl/deserializer_frame_unit.sv
// Serial-to-parallel frame receiver: collects N_WORDS*WORD_W bits MSB-first after a START
// marker and holds the recovered frame until the consumer acknowledges it.
module deserializer_frame_unit #(
    parameter  int WORD_W  = 32,
    parameter  int N_WORDS = 8,
    localparam int F       = N_WORDS * WORD_W,
    localparam int BW      = $clog2(WORD_W),
    localparam int WW      = $clog2(N_WORDS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          SERIAL_IN,
    input  logic          BIT_VALID,
    input  logic          START,
    input  logic          OUT_ACK,
    input  logic          CLR_OVR,
    output logic [F-1:0]  PAR_OUT,
    output logic          OUT_VALID,
    output logic          BUSY,
    output logic          OVERRUN,
    output logic          ABORT,
    output logic [BW-1:0] BIT_COUNT,
    output logic [WW-1:0] WORD_COUNT
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t        state_reg, state_next;
    logic [F-1:0]  shift_reg, shift_next;
    logic [F-1:0]  par_reg, par_next;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    logic [WW-1:0] word_cnt_reg, word_cnt_next;
    logic          out_valid_reg, out_valid_next;
    logic          overrun_reg, overrun_next;
    logic          abort_reg, abort_next;
    logic          busy_comb;

    logic          start_bit;
    logic          shift_bit;
    logic          last_bit;
    logic          load_frame;
    logic [F-1:0]  frame_word;

    // A START bit always begins a new frame, so it takes priority over ordinary shifting.
    assign start_bit  = BIT_VALID && START;
    assign shift_bit  = BIT_VALID && !START && (state_reg == SHIFT);
    assign last_bit   = shift_bit && (bit_cnt_reg == BW'(WORD_W - 1))
                                  && (word_cnt_reg == WW'(N_WORDS - 1));
    assign frame_word = {shift_reg[F-2:0], SERIAL_IN};
    // An acknowledge on the completing edge frees the output register for the new frame.
    assign load_frame = last_bit && (!out_valid_reg || OUT_ACK);

    // FSM: state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_bit) state_next = SHIFT;
            SHIFT:   if (start_bit) state_next = SHIFT;
                     else if (last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_comb = (state_reg == SHIFT);
    end

    always_comb begin
        shift_next     = shift_reg;
        bit_cnt_next   = bit_cnt_reg;
        word_cnt_next  = word_cnt_reg;
        par_next       = par_reg;
        out_valid_next = out_valid_reg;
        overrun_next   = overrun_reg;
        abort_next     = start_bit && (state_reg == SHIFT);

        if (start_bit) begin
            shift_next    = {{(F-1){1'b0}}, SERIAL_IN};
            bit_cnt_next  = BW'(1);
            word_cnt_next = '0;
        end else if (last_bit) begin
            shift_next    = '0;
            bit_cnt_next  = '0;
            word_cnt_next = '0;
        end else if (shift_bit) begin
            shift_next = frame_word;
            if (bit_cnt_reg == BW'(WORD_W - 1)) begin
                bit_cnt_next  = '0;
                word_cnt_next = word_cnt_reg + WW'(1);
            end else begin
                bit_cnt_next  = bit_cnt_reg + BW'(1);
            end
        end

        if (load_frame) begin
            par_next       = frame_word;
            out_valid_next = 1'b1;
        end else if (OUT_ACK) begin
            out_valid_next = 1'b0;
        end

        // Set beats clear when a drop and CLR_OVR land on the same edge.
        if (last_bit && out_valid_reg && !OUT_ACK) begin
            overrun_next = 1'b1;
        end else if (CLR_OVR) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            shift_reg     <= '0;
            par_reg       <= '0;
            bit_cnt_reg   <= '0;
            word_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            shift_reg     <= shift_next;
            par_reg       <= par_next;
            bit_cnt_reg   <= bit_cnt_next;
            word_cnt_reg  <= word_cnt_next;
            out_valid_reg <= out_valid_next;
            overrun_reg   <= overrun_next;
            abort_reg     <= abort_next;
        end
    end

    assign PAR_OUT    = par_reg;
    assign OUT_VALID  = out_valid_reg;
    assign BUSY       = busy_comb;
    assign OVERRUN    = overrun_reg;
    assign ABORT      = abort_reg;
    assign BIT_COUNT  = bit_cnt_reg;
    assign WORD_COUNT = word_cnt_reg;

endmodule

// File: tb/tb_deserializer_frame_unit.sv
// Scoreboard bench for deserializer_frame_unit: stimulus pushes expected frames, a negedge
// monitor pops and compares each frame the DUT presents.
module tb_deserializer_frame_unit;

    localparam int WORD_W  = 32;
    localparam int N_WORDS = 8;
    localparam int F       = WORD_W * N_WORDS;

    localparam logic [F-1:0] FRAME1 = {32'hFFFFFFFF, 32'h3FFFFFFF, 32'h8FFFFFFF, 32'h1FFFFFFF,
                                       32'h00005BA0, 32'h00003044, 32'h000030A8, 32'h00000001};
    localparam logic [F-1:0] FRAME2 = {32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005,
                                       32'h00005BA0, 32'h00003044, 32'h000030A8, 32'h00000001};

    logic         CLK       = 1'b0;
    logic         RESET     = 1'b1;
    logic         SERIAL_IN = 1'b0;
    logic         BIT_VALID = 1'b0;
    logic         START     = 1'b0;
    logic         OUT_ACK   = 1'b0;
    logic         CLR_OVR   = 1'b0;
    logic [F-1:0] PAR_OUT;
    logic         OUT_VALID;
    logic         BUSY;
    logic         OVERRUN;
    logic         ABORT;
    logic [4:0]   BIT_COUNT;
    logic [2:0]   WORD_COUNT;

    int           total      = 0;
    int           bad        = 0;
    logic [F-1:0] exp_q[$];
    int           edge_cnt   = 0;
    int           start_edge = 0;
    int           lat_expect = 0;
    int           abort_seen = 0;
    logic         prev_valid = 1'b0;
    logic         ack_edge   = 1'b0;

    always #5 CLK = ~CLK;

    deserializer_frame_unit #(.WORD_W(WORD_W), .N_WORDS(N_WORDS)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SERIAL_IN  (SERIAL_IN),
        .BIT_VALID  (BIT_VALID),
        .START      (START),
        .OUT_ACK    (OUT_ACK),
        .CLR_OVR    (CLR_OVR),
        .PAR_OUT    (PAR_OUT),
        .OUT_VALID  (OUT_VALID),
        .BUSY       (BUSY),
        .OVERRUN    (OVERRUN),
        .ABORT      (ABORT),
        .BIT_COUNT  (BIT_COUNT),
        .WORD_COUNT (WORD_COUNT)
    );

    task automatic check(input string name, input logic [F-1:0] act, input logic [F-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // A new frame is presented when OUT_VALID rises or is reloaded on an acknowledged edge.
    always @(posedge CLK) begin
        edge_cnt <= edge_cnt + 1;
        ack_edge <= OUT_ACK && OUT_VALID;
    end

    always @(negedge CLK) begin
        logic [F-1:0] exp_frame;
        if (ABORT === 1'b1) abort_seen++;
        if (RESET && OUT_VALID && (!prev_valid || ack_edge)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame: unexpected frame %h, none expected", PAR_OUT);
            end else begin
                exp_frame = exp_q.pop_front();
                check("frame", PAR_OUT, exp_frame);
            end
            if (lat_expect != 0) begin
                check("latency_cycles", F'(edge_cnt - start_edge + 1), F'(lat_expect));
                lat_expect = 0;
            end
        end
        prev_valid = RESET && (OUT_VALID === 1'b1);
    end

    task automatic send_bit(input logic b, input logic st, input logic ack);
        SERIAL_IN = b;
        BIT_VALID = 1'b1;
        START     = st;
        OUT_ACK   = ack;
        @(negedge CLK);
        BIT_VALID = 1'b0;
        START     = 1'b0;
        OUT_ACK   = 1'b0;
    endtask

    task automatic send_frame(input logic [F-1:0] fr, input bit gapped, input bit ack_last,
                              input logic exp_abort);
        int c = 0;
        for (int i = 0; i < F; i++) begin
            if (gapped && (c % 3 == 2)) begin
                @(negedge CLK);
                c++;
                if (i < 70) begin
                    check("gap_bit_count", F'(BIT_COUNT), F'(i % WORD_W));
                    check("gap_word_count", F'(WORD_COUNT), F'(i / WORD_W));
                end
            end
            if (i == 0) start_edge = edge_cnt;
            send_bit(fr[F-1-i], i == 0, ack_last && (i == F - 1));
            c++;
            if (i == 0) begin
                check("abort_on_start", F'(ABORT), F'(exp_abort));
                check("start_bit_count", F'(BIT_COUNT), F'(1));
                check("start_word_count", F'(WORD_COUNT), F'(0));
                check("busy_shift", F'(BUSY), F'(1));
            end
            if (i == 1) check("abort_one_cycle", F'(ABORT), F'(0));
            if (i == 100) begin
                check("mid_bit_count", F'(BIT_COUNT), F'(5));
                check("mid_word_count", F'(WORD_COUNT), F'(3));
            end
            if (i == F - 1) begin
                check("end_busy", F'(BUSY), F'(0));
                check("end_bit_count", F'(BIT_COUNT), F'(0));
                check("end_word_count", F'(WORD_COUNT), F'(0));
            end
        end
    endtask

    task automatic ack_frame();
        OUT_ACK = 1'b1;
        @(negedge CLK);
        OUT_ACK = 1'b0;
        check("ack_clears_valid", F'(OUT_VALID), F'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_par_out"}, PAR_OUT, '0);
        check({tag, "_out_valid"}, F'(OUT_VALID), F'(0));
        check({tag, "_busy"}, F'(BUSY), F'(0));
        check({tag, "_overrun"}, F'(OVERRUN), F'(0));
        check({tag, "_abort"}, F'(ABORT), F'(0));
        check({tag, "_bit_count"}, F'(BIT_COUNT), F'(0));
        check({tag, "_word_count"}, F'(WORD_COUNT), F'(0));
    endtask

    initial begin
        logic [F-1:0] fr;

        #2 RESET = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Bits without START are ignored in IDLE; START with BIT_VALID=0 is ignored too.
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("idle_ignores_bits", F'(BUSY), F'(0));
        check("idle_bit_count", F'(BIT_COUNT), F'(0));

        // Single contiguous frame with latency measurement.
        exp_q.push_back(FRAME1);
        lat_expect = 257;
        send_frame(FRAME1, 1'b0, 1'b0, 1'b0);
        check("valid_after_frame", F'(OUT_VALID), F'(1));
        repeat (2) @(negedge CLK);
        check("held_par_out", PAR_OUT, FRAME1);
        ack_frame();

        // Gapped frame.
        exp_q.push_back(FRAME1);
        send_frame(FRAME1, 1'b1, 1'b0, 1'b0);
        ack_frame();

        // Acknowledge with nothing held has no effect.
        ack_frame();
        check("idle_ack_par_kept", PAR_OUT, FRAME1);

        // Back-to-back frames without acknowledge: second is dropped.
        exp_q.push_back(FRAME1);
        send_frame(FRAME1, 1'b0, 1'b0, 1'b0);
        send_frame(FRAME2, 1'b0, 1'b0, 1'b0);
        check("overrun_set", F'(OVERRUN), F'(1));
        check("overrun_valid", F'(OUT_VALID), F'(1));
        check("overrun_par_kept", PAR_OUT, FRAME1);
        @(negedge CLK);
        check("overrun_sticky", F'(OVERRUN), F'(1));
        CLR_OVR = 1'b1;
        @(negedge CLK);
        CLR_OVR = 1'b0;
        check("overrun_cleared", F'(OVERRUN), F'(0));

        // Acknowledge coincident with the final bit of the next frame.
        exp_q.push_back(FRAME2);
        send_frame(FRAME2, 1'b0, 1'b1, 1'b0);
        check("coincident_valid", F'(OUT_VALID), F'(1));
        check("coincident_par", PAR_OUT, FRAME2);
        check("coincident_no_overrun", F'(OVERRUN), F'(0));
        ack_frame();

        // START reasserted at bit 100 aborts the partial frame.
        fr = FRAME1;
        for (int i = 0; i < 100; i++) send_bit(fr[F-1-i], i == 0, 1'b0);
        exp_q.push_back(FRAME2);
        send_frame(FRAME2, 1'b0, 1'b0, 1'b1);
        check("abort_par", PAR_OUT, FRAME2);

        // Reset at bit 40 with a frame still held, then resume only on START.
        for (int i = 0; i < 40; i++) send_bit(fr[F-1-i], i == 0, 1'b0);
        RESET = 1'b0;
        #1 check_all_zero("midreset");
        for (int i = 0; i < 3; i++) send_bit(fr[F-41-i], 1'b0, 1'b0);
        check_all_zero("heldreset");
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        check("post_reset_idle", F'(BUSY), F'(0));
        check("post_reset_count", F'(BIT_COUNT), F'(0));
        exp_q.push_back(FRAME1);
        send_frame(FRAME1, 1'b0, 1'b0, 1'b0);
        ack_frame();

        repeat (2) @(negedge CLK);
        check("frames_outstanding", F'(exp_q.size()), F'(0));
        check("abort_pulses", F'(abort_seen), F'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
